// File: rtl/prio_enc_rr.sv
// Registered N-to-log2(N) encoder with sticky request buffering and a valid/ready output.
// Selection is fixed priority (MODE 0) or round-robin (MODE 1).
module prio_enc_rr #(
    parameter int N    = 8,
    parameter int MODE = 0,
    localparam int W   = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i,
    input  logic         ready,
    input  logic         clr,
    output logic [W-1:0] y,
    output logic         valid,
    output logic         multi,
    output logic         ovf
);

    localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [N-1:0] pend_q, pend_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] y_q, y_d;
    logic         valid_q, valid_d;
    logic         multi_q, multi_d;
    logic         ovf_q, ovf_d;

    logic [N-1:0] eff;
    logic [N-1:0] grant_mask;
    logic [W-1:0] sel;
    logic         load;
    logic         any_req;
    logic         multi_req;

    assign eff        = pend_q | i;
    assign load       = !valid_q || ready;
    assign any_req    = (eff != '0);
    assign multi_req  = ((eff & (eff - ONE)) != '0);
    assign grant_mask = ONE << sel;

    // Scan from the highest scan position down so the first hit in scan order is the last write.
    always_comb begin
        int idx;
        idx = 0;
        sel = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (MODE == 1) begin
                idx = int'(ptr_q) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
            end else begin
                idx = k;
            end
            if (eff[idx]) begin
                sel = W'(idx);
            end
        end
    end

    always_comb begin
        pend_d  = eff;
        ptr_d   = ptr_q;
        y_d     = y_q;
        valid_d = valid_q;
        multi_d = multi_q;
        ovf_d   = ovf_q;

        // A new overflow beats a simultaneous clear.
        if ((i & pend_q) != '0) begin
            ovf_d = 1'b1;
        end else if (clr) begin
            ovf_d = 1'b0;
        end

        if (load) begin
            if (any_req) begin
                y_d     = sel;
                valid_d = 1'b1;
                multi_d = multi_req;
                pend_d  = eff & ~grant_mask;
                if (MODE == 1) begin
                    ptr_d = (sel == LAST) ? '0 : sel + W'(1);
                end
            end else begin
                valid_d = 1'b0;
                multi_d = 1'b0;
                pend_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            ptr_q   <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
            ovf_q   <= ovf_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;
    assign multi = multi_q;
    assign ovf   = ovf_q;

endmodule

// File: doc/prio_enc_rr.md
# prio_enc_rr

Parametrised, registered N-to-log2(N) encoder with request buffering. It generalises the one-hot 8x3 encoder to any N and adds two selection modes: fixed priority or round-robin. Requests are captured into a sticky pending register and drained one index per handshake through a valid/ready output. It sits between interrupt/event sources and a single consumer that services one source index at a time.

## Interface
- N, default 8: number of request inputs; legal values are N ≥ 2.
- MODE, default 0: selection mode. 0 is fixed priority (lowest index wins). 1 is round-robin.
- W (localparam) = max(1, $clog2(N)): output index width.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- i  input  N  request bits; each set bit is one request for that index, sampled every edge.
- ready  input  1  consumer accepts the current y this cycle.
- clr  input  1  synchronous clear of ovf.
- y  output  W  encoded index of the granted request; registered.
- valid  output  1  y holds an ungranted index; registered.
- multi  output  1  more than one request was eligible when y was loaded; registered.
- ovf  output  1  sticky flag: a request was lost; registered.

## Operation
- State:
  - pend[N-1:0]: pending requests.
  - ptr[W-1:0]: round-robin start index.
  - Output registers y, valid, multi, ovf.
- eff = pend | i: the eligible set this cycle.
- load = !valid || ready: the output register may take a new index.
- Selection sel(eff):
  - MODE 0: lowest set index of eff.
  - MODE 1: first set index found scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
- On each edge when load is 1:
  - If eff ≠ 0: y ← sel; valid ← 1; multi ← (popcount(eff) > 1); pend ← eff & ~(1 << sel).
  - In MODE 1 only, also ptr ← (sel == N-1) ? 0 : sel+1. The wrap is at N-1, not at 2^W−1.
  - If eff == 0: valid ← 0, multi ← 0, pend ← 0. y holds its last value.
- On each edge when load is 0:
  - pend ← eff.
  - y, valid and multi hold.
- In MODE 0, ptr stays 0.
- ovf:
  - Set when (i & pend) ≠ 0, i.e. a request arrives for an index already pending.
  - A request matching the index currently held in y is not an overflow, because that index has already left pend.
  - clr clears ovf. If clr and a new overflow occur in the same cycle, the set wins.
- Illegal y values are never produced: y < N whenever valid = 1.

## Timing
- Reset (rst_n low, asynchronous, effective immediately, including mid-operation): pend = 0, ptr = 0, y = 0, valid = 0, multi = 0, ovf = 0. All pending and in-flight requests are discarded.
- Latency: a request on i before edge E, with load true, appears on y/valid after E. That is one cycle.
- Throughput: one index per cycle while ready = 1 and eff ≠ 0.
- Handshake:
  - A transfer occurs on an edge where valid && ready.
  - While valid && !ready, y, valid and multi are stable.
  - ready is a don't-care when valid = 0.
- Simultaneous events: a transfer and new requests in the same cycle are both honoured. The next y is chosen from the pend | i of that cycle.
- No combinational path from i or ready to any output.

## Test plan
- Reset: with N=8, load pend = 8'hA5 and valid = 1 under ready = 0, then pulse rst_n low mid-cycle → all outputs read 0 before the next edge. After release, the first edge with i = 0 gives valid = 0.
- Fixed priority (N=8, MODE=0, ready=1): i = 8'b1000_0001 for one cycle → y=0, multi=1; next cycle y=7, multi=0; next cycle valid=0.
- Backpressure and overflow (MODE=0, ready=0):
  - i = 8'h04 → y=2, valid=1.
  - i = 8'h04 again → pend = 8'h04, ovf=0.
  - i = 8'h04 a third time → ovf=1.
  - ready=1 → y=2 is reissued once more, then valid=0.
  - clr=1 → ovf=0.
- Round-robin fairness (N=8, MODE=1, ready=1):
  - i = 8'hFF for one cycle → y = 0,1,…,7 on consecutive cycles, then ptr = 0.
  - Then i = 8'h01 → y = 0, ptr = 1.
  - Then i = 8'h03 held one cycle → y = 1, then y = 0.
- Non-power-of-two wrap (N=5, MODE=1):
  - Grant index 3 → ptr = 4.
  - i = 5'b10001 → y = 4, then y = 0.
  - Confirm y never exceeds 4 and ptr wraps 4 → 0.
- Continuous streaming (MODE=0, ready=1): i = 8'h10 every cycle → valid stays 1, y = 4 every cycle, ovf stays 0, multi stays 0.
